sha256_round_engine: RTL

//  Sequential SHA-256 compression core. It is the consumer of the T1/T2 round terms.
//  - Loads an 8-word chaining state.
//  - Accepts the 64 message-schedule words W[t] over a valid/ready stream, one round per accepted word.
//  - Applies the round update a'=T1+T2, e'=d+T1, then adds the chaining state back in.

---
 rtl/sha256_pkg.sv | 70 +++++++
 rtl/sha256_t1.sv | 22 ++
 rtl/sha256_round_engine.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared SHA-256 constants (K table, IV), FSM encodings and
//                the round helper functions used by the compression core.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_round = 2'd1;
    localparam logic [1:0] c_st_final = 2'd2;

    localparam logic [255:0] c_iv = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] c_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] k_const(input logic [5:0] t);
        return c_k[t];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] t2(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
        return big_sigma0(a) + maj(a, b, c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_t1.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_t1
//  Description : Combinational SHA-256 T1 term: h + Sigma1(e) + Ch(e,f,g) + K + W.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_t1
    import sha256_pkg::*;
(
    input  logic [31:0] i_e,
    input  logic [31:0] i_f,
    input  logic [31:0] i_g,
    input  logic [31:0] i_h,
    input  logic [31:0] i_k,
    input  logic [31:0] i_w,
    output logic [31:0] o_t1
);

    assign o_t1 = i_h + big_sigma1(i_e) + ch(i_e, i_f, i_g) + i_k + i_w;

endmodule
`default_nettype wire

// File: rtl/sha256_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_round_engine
//  Description : Sequential SHA-256 compression core, one round per accepted
//                schedule word, followed by the chaining-state feed-forward.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*WORD_W-1:0]   state_in,
    input  logic [WORD_W-1:0]     w_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [8*WORD_W-1:0]   hash_out,
    output logic                  done,
    output logic                  busy
);

    localparam logic [5:0] c_t_last = 6'(ROUNDS - 1);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [5:0]   r_t;
    logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [255:0] r_chain;
    logic [255:0] r_hash;
    logic         r_done;

    logic         w_accept;
    logic [31:0]  w_k;
    logic [31:0]  w_t1;
    logic [31:0]  w_t2;
    logic [255:0] w_work;
    logic [255:0] w_final;

    assign w_accept = (r_state == c_st_round) && w_valid;
    assign w_k      = k_const(r_t);
    assign w_t2     = t2(r_a, r_b, r_c);
    assign w_work   = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};

    sha256_t1 u_t1 (
        .i_e  (r_e),
        .i_f  (r_f),
        .i_g  (r_g),
        .i_h  (r_h),
        .i_k  (w_k),
        .i_w  (w_data),
        .o_t1 (w_t1)
    );

    // Feed-forward is per 32-bit word so carries never cross word boundaries.
    for (genvar i = 0; i < 8; i++) begin : g_final
        assign w_final[i*32 +: 32] = r_chain[i*32 +: 32] + w_work[i*32 +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (start) w_state_nxt = c_st_round;
            c_st_round: if (w_accept && (r_t == c_t_last)) w_state_nxt = c_st_final;
            c_st_final: w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_t     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_e     <= '0;
            r_f     <= '0;
            r_g     <= '0;
            r_h     <= '0;
            r_chain <= '0;
            r_hash  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_t <= '0;
                    if (start) begin
                        {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= state_in;
                        r_chain <= state_in;
                    end
                end
                c_st_round: begin
                    if (w_accept) begin
                        r_h <= r_g;
                        r_g <= r_f;
                        r_f <= r_e;
                        r_e <= r_d + w_t1;
                        r_d <= r_c;
                        r_c <= r_b;
                        r_b <= r_a;
                        r_a <= w_t1 + w_t2;
                        // Counter parks on the last round; IDLE clears it.
                        if (r_t != c_t_last) begin
                            r_t <= r_t + 6'd1;
                        end
                    end
                end
                c_st_final: begin
                    r_hash <= w_final;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_ready  = (r_state == c_st_round);
    assign busy     = (r_state != c_st_idle);
    assign done     = r_done;
    assign hash_out = r_hash;

endmodule
`default_nettype wire
